// File: rtl/reg_dump_streamer_pkg.sv
// Shared types and constants for the register dump streamer.
package reg_dump_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2,
    ST_CHK  = 2'd3
  } state_e;

  localparam logic [7:0] HDR_FULL_DEF   = 8'hA5;
  localparam logic [7:0] HDR_SINGLE_DEF = 8'h5A;

  // Total bytes on the wire: header + body + checksum.
  localparam int FULL_FRAME_LEN   = 34;
  localparam int SINGLE_FRAME_LEN = 4;

  // Select register idx from a 256-bit image (r0 in the top byte).
  // Written as an explicit 32-way mux rather than a variable shift.
  function automatic logic [7:0] reg_byte(input logic [255:0] img,
                                          input logic [4:0]   idx);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 32; i++) begin
      if (idx == 5'(i)) r = img[255 - 8*i -: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dump_checksum.sv
// 8-bit running sum of frame bytes; cleared when a frame is accepted.
module dump_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       add,
  input  logic [7:0] din,
  output logic [7:0] sum
);

  logic [7:0] sum_q, sum_d;

  // Next-value: clear wins over add; add wraps modulo 256.
  always_comb begin
    sum_d = sum_q;
    if (clr)      sum_d = 8'h00;
    else if (add) sum_d = sum_q + din;
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) sum_q <= 8'h00;
    else     sum_q <= sum_d;
  end

  assign sum = sum_q;

endmodule

// File: rtl/reg_dump_streamer.sv
// Streams a captured register-file image (or one register) as a framed
// byte stream with a ready/valid handshake and a trailing additive checksum.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no frame; accepts dumpReq (priority) or readReq
// HDR     | presenting the header byte
// BODY    | presenting data bytes indexed by cnt (32 for full, 2 single)
// CHK     | presenting the checksum; its transfer returns to IDLE + done
module reg_dump_streamer
  import reg_dump_streamer_pkg::*;
#(
  parameter logic [7:0] HDR_FULL   = HDR_FULL_DEF,
  parameter logic [7:0] HDR_SINGLE = HDR_SINGLE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dumpReq,
  input  logic         readReq,
  input  logic [4:0]   readAddr,
  input  logic [255:0] regSnapshot,
  output logic [7:0]   txData,
  output logic         txValid,
  input  logic         txReady,
  output logic         busy,
  output logic         done
);

  // Last body index: body length is frame length minus header and checksum.
  localparam logic [4:0] LAST_FULL   = 5'(FULL_FRAME_LEN - 3);
  localparam logic [4:0] LAST_SINGLE = 5'(SINGLE_FRAME_LEN - 3);

  state_e         state_q, state_d;
  logic [255:0]   snap_q, snap_d;
  logic [4:0]     addr_q, addr_d;
  logic [7:0]     val_q, val_d;
  logic           full_q, full_d;
  logic [4:0]     cnt_q, cnt_d;
  logic           done_q, done_d;

  logic           sum_clr;
  logic           sum_add;
  logic [7:0]     sum;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic [7:0]     body_byte;
  logic [4:0]     last_idx;

  // Body byte: full dump indexes the captured image; single frame sends
  // the address then the captured value.
  always_comb begin
    body_byte = 8'h00;
    if (full_q)             body_byte = reg_byte(snap_q, cnt_q);
    else if (cnt_q == 5'd0) body_byte = {3'b000, addr_q};
    else                    body_byte = val_q;
  end

  assign last_idx = full_q ? LAST_FULL : LAST_SINGLE;

  // Next-state, capture and output logic.
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    addr_d   = addr_q;
    val_d    = val_q;
    full_d   = full_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    sum_clr  = 1'b0;
    sum_add  = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dumpReq) begin
          state_d = ST_HDR;
          full_d  = 1'b1;
          snap_d  = regSnapshot;
          cnt_d   = 5'd0;
          sum_clr = 1'b1;
        end else if (readReq) begin
          state_d = ST_HDR;
          full_d  = 1'b0;
          addr_d  = readAddr;
          val_d   = reg_byte(regSnapshot, readAddr);
          cnt_d   = 5'd0;
          sum_clr = 1'b1;
        end
      end
      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = full_q ? HDR_FULL : HDR_SINGLE;
        if (txReady) begin
          sum_add = 1'b1;
          state_d = ST_BODY;
        end
      end
      ST_BODY: begin
        tx_valid = 1'b1;
        tx_data  = body_byte;
        if (txReady) begin
          sum_add = 1'b1;
          if (cnt_q == last_idx) begin
            state_d = ST_CHK;
            cnt_d   = 5'd0;
          end else begin
            cnt_d   = cnt_q + 5'd1;
          end
        end
      end
      ST_CHK: begin
        tx_valid = 1'b1;
        tx_data  = sum;
        if (txReady) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and capture registers; reset overrides any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      addr_q  <= '0;
      val_q   <= '0;
      full_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      addr_q  <= addr_d;
      val_q   <= val_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  dump_checksum u_chk (
    .clk (clk),
    .rst (rst),
    .clr (sum_clr),
    .add (sum_add),
    .din (tx_data),
    .sum (sum)
  );

  assign txData  = tx_data;
  assign txValid = tx_valid;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;

endmodule

// File: doc/reg_dump_streamer.md
REG_DUMP_STREAMER -- requirements
Module: reg_dump_streamer

Interface
REQ-001 Parameter HDR_FULL, default 8'hA5, header byte of a full-dump frame.
REQ-002 Parameter HDR_SINGLE, default 8'h5A, header byte of a single-register frame.
REQ-003 Ports: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 dumpReq  in  1  start a full 32-register dump frame.
REQ-007 readReq  in  1  start a single-register frame.
REQ-008 readAddr  in  5  register index for readReq.
REQ-009 regSnapshot  in  256  live register-file image; r0 at [255:248], r31 at [7:0].
REQ-010 txData  out  8  byte presented to the downstream byte sink.
REQ-011 txValid  out  1  txData holds a valid byte.
REQ-012 txReady  in  1  sink accepts the byte; a transfer occurs on a cycle with txValid and txReady both high.
REQ-013 busy  out  1  frame in progress.
REQ-014 done  out  1  one-cycle pulse after the final byte of a frame transfers.

Function
REQ-015 States: IDLE, HDR, BODY, CHK.
REQ-016 In IDLE, a request sampled high is accepted; dumpReq has priority over readReq when both are high.
REQ-017 On acceptance, the SHALL capture: full dump = all 256 bits of regSnapshot; single = readAddr and regs[readAddr]; later regSnapshot changes do not affect the frame.
REQ-018 Latency: request accepted at edge N -> txValid=1 with the header byte in the cycle after edge N; busy=1 over the same interval.
REQ-019 Full frame byte order: HDR_FULL, r0, r1, ..., r31, checksum (34 bytes).
REQ-020 Single frame byte order: HDR_SINGLE, {3'b000, addr}, value, checksum (4 bytes).
REQ-021 Checksum = 8-bit sum, modulo 256, of every preceding byte in the frame, header included.
REQ-022 While txValid=1 and txReady=0, txData and txValid hold stable.
REQ-023 After a transfer, the next byte is presented in the following cycle, with no bubble; with txReady held high, one byte transfers per cycle.
REQ-024 A 5-bit BODY byte counter indexes the snapshot; leaving BODY occurs after index 31 (full) or index 1 (single) transfers, and the counter does not wrap into a 33rd data byte.
REQ-025 After the checksum transfers, the next state is IDLE; done=1, busy=0 and txValid=0 for that one cycle.
REQ-026 A request arriving in the done cycle is accepted, since the state is IDLE.
REQ-027 Requests arriving while busy=1 are ignored and not queued.
REQ-028 txValid=0 in IDLE; txData=8'h00 whenever txValid=0.

Reset
REQ-029 rst=1 at an edge forces IDLE, with txValid=0, txData=0, busy=0, done=0, and the counter and checksum cleared.
REQ-030 Reset mid-frame aborts the frame; no further bytes of that frame appear, and no done pulse follows.
REQ-031 rst has priority over any request sampled at the same edge.

Structure
REQ-032 A shared package holds the state enum, HDR_FULL/HDR_SINGLE defaults, and the frame-length constants (34, 4).
REQ-033 One sub-module, dump_checksum, is used: an 8-bit accumulator with clear and add-on-transfer inputs.
REQ-034 The snapshot is a 256-bit register; byte selection is a mux on the counter, not a shift of live input.

Verification
REQ-035 All regs 8'h00, dumpReq pulse, txReady=1 -> 34 consecutive bytes A5, 32x00, A5; done 1 cycle after the last byte.
REQ-036 All regs 8'h01, dumpReq -> body 32x01, checksum 8'hC5.
REQ-037 readReq with readAddr=26 and r26=8'h34 -> bytes 5A, 1A, 34, A8.
REQ-038 txReady toggling 1/0 during a full dump -> txData stable on stall cycles, byte order and checksum unchanged; regSnapshot altered mid-frame -> no effect.
REQ-039 dumpReq and readReq high in the same cycle -> full frame; dumpReq pulsed while busy -> ignored, exactly one frame produced.
REQ-040 rst asserted after the 10th byte -> next cycle txValid=0, busy=0, done never pulses; a subsequent dumpReq produces a complete, correct frame.
